// File: rtl/note_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : note_seq_pkg
//  Description : Shared types and constants for the note track sequencer.
//                Holds the sequencer state encoding, default geometry of the
//                note RAM and a depth helper.
//  Revision    : 1.0  initial release
// ============================================================================
package note_seq_pkg;

    // Sequencer state; the encoding is visible on state_o
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_NOTE_W = 32;

    // Number of words addressable with an aw-bit address
    function automatic int f_depth(input int aw);
        return 1 << aw;
    endfunction

    localparam int MAX_DEPTH = f_depth(DEF_ADDR_W);

endpackage : note_seq_pkg
`default_nettype wire

// File: rtl/note_ram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : note_ram_arb
//  Description : Single-port note RAM arbiter. The sequencer has fixed
//                priority in its tick-access cycle; the display reader gets
//                the port in every other cycle it requests it. Granted
//                display reads return one cycle later (RAM latency).
//  Ports       : clk/resetn      clock, synchronous active-low reset
//                i_seq_*         sequencer access request, address, write
//                i_disp_req/addr display read request
//                o_disp_*        grant, data-valid pulse and read data
//                o_ram_* / i_ram_q  RAM port
//  Revision    : 1.0  initial release
// ============================================================================
module note_ram_arb
    import note_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NOTE_W = DEF_NOTE_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_seq_access,
    input  logic              i_seq_wren,
    input  logic [ADDR_W-1:0] i_seq_addr,
    input  logic [NOTE_W-1:0] i_seq_wdata,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_disp_gnt,
    output logic              o_disp_valid,
    output logic [NOTE_W-1:0] o_disp_data,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_wren,
    output logic [NOTE_W-1:0] o_ram_wdata,
    input  logic [NOTE_W-1:0] i_ram_q
);

    logic w_gnt;
    logic r_disp_valid;

    assign w_gnt = i_disp_req & ~i_seq_access;

    // When nobody owns the port the address rests on the sequencer pointer
    assign o_ram_addr  = w_gnt ? i_disp_addr : i_seq_addr;
    assign o_ram_wren  = i_seq_access & i_seq_wren;
    assign o_ram_wdata = o_ram_wren ? i_seq_wdata : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_valid <= w_gnt;
        end
    end

    assign o_disp_gnt   = w_gnt;
    assign o_disp_valid = r_disp_valid;
    assign o_disp_data  = i_ram_q;

endmodule : note_ram_arb
`default_nettype wire

// File: rtl/note_track_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : note_track_sequencer
//  Description : Record/playback sequencer for the single-port note RAM.
//                One RAM access per tempo tick; owns the pointer, the
//                recorded track length and the write enable. Idle RAM
//                cycles are lent to the display reader via note_ram_arb.
//  Ports       : clk, resetn (sync, active-low); tick; cmd_record/play/stop;
//                loop_en; note_in; disp_req/addr -> disp_gnt/valid/data;
//                ram_addr/wren/wdata, ram_q; note_out/note_valid; cur_addr;
//                track_len; state_o; overflow; loop_cnt (optional).
//  Options     : NOTE_SEQ_LOOP_COUNT_EN adds loop_cnt[7:0], the number of
//                playback wraps since the last accepted cmd_play (saturating).
//  Revision    : 1.0  initial release
// ============================================================================
module note_track_sequencer
    import note_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NOTE_W = DEF_NOTE_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tick,
    input  logic              cmd_record,
    input  logic              cmd_play,
    input  logic              cmd_stop,
    input  logic              loop_en,
    input  logic [NOTE_W-1:0] note_in,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [NOTE_W-1:0] disp_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [NOTE_W-1:0] ram_wdata,
    input  logic [NOTE_W-1:0] ram_q,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W:0]   track_len,
    output logic [1:0]        state_o,
    output logic              overflow
`ifdef NOTE_SEQ_LOOP_COUNT_EN
    ,
    output logic [7:0]        loop_cnt
`endif
);

    localparam int              C_DEPTH_I = f_depth(ADDR_W);
    localparam logic [ADDR_W:0] C_DEPTH   = C_DEPTH_I[ADDR_W:0];
    localparam logic [ADDR_W-1:0] C_LAST  = {ADDR_W{1'b1}};

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_track_len;
    logic              r_overflow;
    logic [NOTE_W-1:0] r_note_out;
    logic              r_note_valid;
    logic              r_rd_pending;   // read issued last cycle, ram_q valid now
    logic              r_end_pending;  // final non-looping read in flight
`ifdef NOTE_SEQ_LOOP_COUNT_EN
    logic [7:0]        r_loop_cnt;
`endif

    logic w_rec_access;
    logic w_play_access;
    logic w_seq_access;
    logic w_at_end;

    // Stop beats a coincident tick; once the last note is in flight further
    // ticks are ignored until the return to IDLE.
    assign w_rec_access  = (r_state == ST_REC)  & tick & ~cmd_stop;
    assign w_play_access = (r_state == ST_PLAY) & tick & ~cmd_stop & ~r_end_pending;
    assign w_seq_access  = w_rec_access | w_play_access;
    assign w_at_end      = ({1'b0, r_ptr} == (r_track_len - 1'b1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_track_len   <= '0;
            r_overflow    <= 1'b0;
            r_note_out    <= '0;
            r_note_valid  <= 1'b0;
            r_rd_pending  <= 1'b0;
            r_end_pending <= 1'b0;
`ifdef NOTE_SEQ_LOOP_COUNT_EN
            r_loop_cnt    <= '0;
`endif
        end else begin
            r_note_valid <= 1'b0;
            r_rd_pending <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // cmd_stop has top priority and masks the others
                    if (!cmd_stop) begin
                        if (cmd_record) begin
                            r_state     <= ST_REC;
                            r_ptr       <= '0;
                            r_overflow  <= 1'b0;
                            r_track_len <= '0;
                        end else if (cmd_play && (r_track_len != '0)) begin
                            r_state       <= ST_PLAY;
                            r_ptr         <= '0;
                            r_end_pending <= 1'b0;
`ifdef NOTE_SEQ_LOOP_COUNT_EN
                            r_loop_cnt    <= '0;
`endif
                        end
                    end
                end

                ST_REC: begin
                    if (cmd_stop) begin
                        r_state     <= ST_IDLE;
                        r_track_len <= {1'b0, r_ptr};
                    end else if (w_rec_access) begin
                        if (r_ptr == C_LAST) begin
                            r_state     <= ST_IDLE;
                            r_track_len <= C_DEPTH;
                            r_overflow  <= 1'b1;
                            r_ptr       <= '0;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end

                ST_PLAY: begin
                    if (cmd_stop) begin
                        // Drop any in-flight read; its note_valid never appears
                        r_state       <= ST_IDLE;
                        r_note_out    <= '0;
                        r_end_pending <= 1'b0;
                    end else begin
                        if (r_rd_pending) begin
                            r_note_out   <= ram_q;
                            r_note_valid <= 1'b1;
                        end
                        // Last note has been presented for a cycle: finish
                        if (r_note_valid && r_end_pending) begin
                            r_state       <= ST_IDLE;
                            r_note_out    <= '0;
                            r_end_pending <= 1'b0;
                            r_ptr         <= '0;
                        end else if (w_play_access) begin
                            r_rd_pending <= 1'b1;
                            if (w_at_end) begin
                                if (loop_en) begin
                                    r_ptr <= '0;
`ifdef NOTE_SEQ_LOOP_COUNT_EN
                                    if (r_loop_cnt != 8'hFF) begin
                                        r_loop_cnt <= r_loop_cnt + 8'd1;
                                    end
`endif
                                end else begin
                                    r_end_pending <= 1'b1;
                                end
                            end else begin
                                r_ptr <= r_ptr + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    note_ram_arb #(
        .ADDR_W (ADDR_W),
        .NOTE_W (NOTE_W)
    ) u_arb (
        .clk          (clk),
        .resetn       (resetn),
        .i_seq_access (w_seq_access),
        .i_seq_wren   (w_rec_access),
        .i_seq_addr   (r_ptr),
        .i_seq_wdata  (note_in),
        .i_disp_req   (disp_req),
        .i_disp_addr  (disp_addr),
        .o_disp_gnt   (disp_gnt),
        .o_disp_valid (disp_valid),
        .o_disp_data  (disp_data),
        .o_ram_addr   (ram_addr),
        .o_ram_wren   (ram_wren),
        .o_ram_wdata  (ram_wdata),
        .i_ram_q      (ram_q)
    );

    assign note_out   = r_note_out;
    assign note_valid = r_note_valid;
    assign cur_addr   = r_ptr;
    assign track_len  = r_track_len;
    assign state_o    = r_state;
    assign overflow   = r_overflow;
`ifdef NOTE_SEQ_LOOP_COUNT_EN
    assign loop_cnt   = r_loop_cnt;
`endif

endmodule : note_track_sequencer
`default_nettype wire
